spi_byte_packer: RTL and testbench

- Sits directly downstream of SpiBuffer and upstream of the Avalon debug/readout logic.
- Takes the 8-bit byte and change strobe that SpiBuffer produces in the SPI clock domain.
- Synchronises them into the system clock, packs bytes little-endian into 64-bit words and flushes partial words at frame end (CS deassert).
- Buffers words in a small FIFO with a valid/ready output.

---
 rtl/spi_byte_packer.sv | 174 +++++++++++++++++
 tb/tb_spi_byte_packer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_packer
//  Description : Brings the SpiBuffer byte and its change strobe from the SPI
//                clock domain into the system clock, then packs bytes
//                little-endian into 64-bit words. A rising chip-select
//                flushes a partial word. Words are queued in a small FIFO
//                with a valid/ready output.
//
//  Ports       : clock, reset         - system clock, async active-high reset
//                io_InputBuffer       - byte from SpiBuffer (quasi-static)
//                io_BufferChanged     - async byte-complete strobe (rise = new byte)
//                io_ChipSelect        - async raw SPI CS (1 = deselected)
//                io_Out_valid/ready   - FIFO head handshake
//                io_Out_data          - head word, frame byte k in [8k+7:8k]
//                io_Out_count         - valid bytes in head word (1..8)
//                io_Level             - FIFO occupancy (0..DEPTH)
//                io_Overflow          - sticky word-dropped flag
//                io_ClearOverflow     - synchronous clear of io_Overflow
//
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_packer #(
    parameter int DEPTH   = 4,
    parameter int LEVEL_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         io_InputBuffer,
    input  logic               io_BufferChanged,
    input  logic               io_ChipSelect,
    output logic               io_Out_valid,
    input  logic               io_Out_ready,
    output logic [63:0]        io_Out_data,
    output logic [3:0]         io_Out_count,
    output logic [LEVEL_W-1:0] io_Level,
    output logic               io_Overflow,
    input  logic               io_ClearOverflow
);

    localparam int c_ADDR_W = LEVEL_W - 1;

    // ------------------------------------------------------------------------
    // Synchronisers. Bit 0 = first flop, bit 1 = second flop, bit 2 = edge
    // detect history. The event is registered once more so the packer always
    // acts on a clean single-cycle pulse.
    // ------------------------------------------------------------------------
    logic [2:0] r_chg_sync;
    logic [2:0] r_cs_sync;
    logic       r_byte_evt;
    logic       r_frame_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chg_sync  <= 3'b000;
            // CS chain starts deselected so leaving reset cannot look like a
            // rising CS edge.
            r_cs_sync   <= 3'b111;
            r_byte_evt  <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_chg_sync  <= {r_chg_sync[1:0], io_BufferChanged};
            r_cs_sync   <= {r_cs_sync[1:0], io_ChipSelect};
            r_byte_evt  <= r_chg_sync[1] & ~r_chg_sync[2];
            r_frame_end <= r_cs_sync[1] & ~r_cs_sync[2];
        end
    end

    // ------------------------------------------------------------------------
    // Packer. io_InputBuffer is sampled directly: the byte has been stable for
    // many system clocks by the time the synchronised event arrives.
    // ------------------------------------------------------------------------
    logic [3:0]  r_idx;
    logic [63:0] r_pack;
    logic [5:0]  w_shamt;
    logic [63:0] w_word;
    logic [3:0]  w_count;
    logic        w_push;

    always_comb begin
        w_shamt = {r_idx[2:0], 3'b000};
        w_word  = r_pack;
        if (r_byte_evt) begin
            w_word = r_pack | ({56'd0, io_InputBuffer} << w_shamt);
        end
        // Byte is folded in before any flush, so a simultaneous byte and
        // frame end produce one word that includes that byte.
        w_count = r_idx + {3'd0, r_byte_evt};
        w_push  = (w_count == 4'd8) || (r_frame_end && (w_count != 4'd0));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx  <= 4'd0;
            r_pack <= 64'd0;
        end else if (w_push) begin
            // Cleared whether or not the FIFO accepted the word.
            r_idx  <= 4'd0;
            r_pack <= 64'd0;
        end else if (r_byte_evt) begin
            r_idx  <= w_count;
            r_pack <= w_word;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO. Pointers carry one extra bit so full and empty are distinguished
    // by the pointer difference alone.
    // ------------------------------------------------------------------------
    logic [63:0]        r_mem_data  [DEPTH];
    logic [3:0]         r_mem_count [DEPTH];
    logic [LEVEL_W-1:0] r_wptr;
    logic [LEVEL_W-1:0] r_rptr;
    logic               r_overflow;
    logic [LEVEL_W-1:0] w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic               w_drop;

    always_comb begin
        w_level = r_wptr - r_rptr;
        w_empty = (w_level == '0);
        w_full  = (w_level == LEVEL_W'(DEPTH));
        w_pop   = ~w_empty & io_Out_ready;
        // A pop in the same cycle frees the slot for a push into a full FIFO.
        w_wr_en = w_push & (~w_full | w_pop);
        w_drop  = w_push & w_full & ~w_pop;
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem_data[r_wptr[c_ADDR_W-1:0]]  <= w_word;
            r_mem_count[r_wptr[c_ADDR_W-1:0]] <= w_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Set has priority over clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (io_ClearOverflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Outputs depend only on registers; io_Out_ready affects only the pop.
    always_comb begin
        io_Out_valid = ~w_empty;
        io_Out_data  = 64'd0;
        io_Out_count = 4'd0;
        if (!w_empty) begin
            io_Out_data  = r_mem_data[r_rptr[c_ADDR_W-1:0]];
            io_Out_count = r_mem_count[r_rptr[c_ADDR_W-1:0]];
        end
        io_Level    = w_level;
        io_Overflow = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_byte_packer
//  Description : Self-checking bench for spi_byte_packer. A queue-based model
//                builds expected words from the byte/frame stream; a monitor
//                compares every popped word against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_byte_packer;

    localparam int DEPTH   = 4;
    localparam int LEVEL_W = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         io_InputBuffer = 8'd0;
    logic               io_BufferChanged = 1'b0;
    logic               io_ChipSelect = 1'b1;
    logic               io_Out_valid;
    logic               io_Out_ready = 1'b1;
    logic [63:0]        io_Out_data;
    logic [3:0]         io_Out_count;
    logic [LEVEL_W-1:0] io_Level;
    logic               io_Overflow;
    logic               io_ClearOverflow = 1'b0;

    spi_byte_packer #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_InputBuffer   (io_InputBuffer),
        .io_BufferChanged (io_BufferChanged),
        .io_ChipSelect    (io_ChipSelect),
        .io_Out_valid     (io_Out_valid),
        .io_Out_ready     (io_Out_ready),
        .io_Out_data      (io_Out_data),
        .io_Out_count     (io_Out_count),
        .io_Level         (io_Level),
        .io_Overflow      (io_Overflow),
        .io_ClearOverflow (io_ClearOverflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  count;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] m_bytes[$];
    logic       m_overflow = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_cycles = 0;

    // ---------------- reference model ----------------
    function automatic void model_push_word();
        word_t w;
        w.data  = 64'd0;
        w.count = 4'(m_bytes.size());
        foreach (m_bytes[k]) w.data[8*k +: 8] = m_bytes[k];
        m_bytes.delete();
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else m_overflow = 1'b1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        m_bytes.push_back(b);
        if (m_bytes.size() == 8) model_push_word();
    endfunction

    function automatic void model_frame_end();
        if (m_bytes.size() > 0) model_push_word();
    endfunction

    // ---------------- output monitor / scoreboard ----------------
    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            if (io_Out_valid) begin
                valid_cycles++;
                if (io_Out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL pop_unexpected: got data=%h count=%0d, expected no word", io_Out_data, io_Out_count);
                    end else begin
                        word_t w;
                        w = exp_q.pop_front();
                        if (io_Out_data !== w.data || io_Out_count !== w.count) begin
                            n_errors++;
                            $display("FAIL pop_word: got data=%h count=%0d, expected data=%h count=%0d", io_Out_data, io_Out_count, w.data, w.count);
                        end
                    end
                end
            end else begin
                n_checks++;
                if (io_Out_data !== 64'd0 || io_Out_count !== 4'd0) begin
                    n_errors++;
                    $display("FAIL empty_head: got data=%h count=%0d, expected 0/0", io_Out_data, io_Out_count);
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_byte(input logic [7:0] b, input bit with_cs);
        @(negedge clock);
        io_InputBuffer   = b;
        io_BufferChanged = 1'b1;
        if (with_cs) io_ChipSelect = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        model_byte(b);
        if (with_cs) model_frame_end();
        @(negedge clock);
        io_BufferChanged = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic cs_end();
        @(negedge clock);
        io_ChipSelect = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        model_frame_end();
        repeat (3) @(negedge clock);
    endtask

    task automatic cs_start();
        @(negedge clock);
        io_ChipSelect = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clock);
        repeat (3) @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (io_Out_valid !== 1'b0 || io_Out_data !== 64'd0 || io_Out_count !== 4'd0 ||
            io_Level !== '0 || io_Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h count=%0d level=%0d ovf=%b, expected all 0",
                     io_Out_valid, io_Out_data, io_Out_count, io_Level, io_Overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (io_Out_valid !== 1'b0 || io_Level !== '0) begin
            n_errors++;
            $display("FAIL reset_release: got valid=%b level=%0d, expected 0/0", io_Out_valid, io_Level);
        end
    endtask

    task automatic test_full_word();
        logic [7:0] bytes [8] = '{8'h7A, 8'h80, 8'h0C, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
        int v0;
        io_Out_ready = 1'b1;
        cs_start();
        v0 = valid_cycles;
        foreach (bytes[i]) send_byte(bytes[i], 1'b0);
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 1) begin
            n_errors++;
            $display("FAIL full_word_valid_cycles: got %0d, expected 1", valid_cycles - v0);
        end
        n_checks++;
        if (exp_q.size() != 0 || io_Level !== '0) begin
            n_errors++;
            $display("FAIL full_word_drain: got pending=%0d level=%0d, expected 0/0", exp_q.size(), io_Level);
        end
    endtask

    task automatic test_partial_flush();
        int v0;
        v0 = valid_cycles;
        send_byte(8'h7A, 1'b0);
        send_byte(8'h80, 1'b0);
        cs_end();
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL partial_word: got words=%0d pending=%0d, expected 1/0", valid_cycles - v0, exp_q.size());
        end
        cs_start();
        v0 = valid_cycles;
        cs_end();
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 0 || io_Level !== '0) begin
            n_errors++;
            $display("FAIL empty_frame_end: got words=%0d level=%0d, expected 0/0", valid_cycles - v0, io_Level);
        end
    endtask

    task automatic test_simultaneous();
        int v0;
        cs_start();
        v0 = valid_cycles;
        for (int i = 1; i <= 7; i++) send_byte(8'(i * 8'h11), 1'b0);
        send_byte(8'h88, 1'b1);
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL byte_and_cs_same_cycle: got words=%0d pending=%0d, expected 1/0", valid_cycles - v0, exp_q.size());
        end
    endtask

    task automatic test_latency();
        io_Out_ready = 1'b0;
        cs_start();
        send_byte(8'h5C, 1'b0);
        @(negedge clock);
        io_ChipSelect = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (io_Out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL latency_early: got valid=%b after edge N+2, expected 0", io_Out_valid);
        end
        @(posedge clock);
        #1;
        model_frame_end();
        n_checks++;
        if (io_Out_valid !== 1'b1 || io_Out_count !== 4'd1) begin
            n_errors++;
            $display("FAIL latency_edge3: got valid=%b count=%0d after edge N+3, expected 1/1", io_Out_valid, io_Out_count);
        end
        @(negedge clock);
        io_Out_ready = 1'b1;
        drain();
    endtask

    task automatic test_overflow();
        io_Out_ready = 1'b0;
        cs_start();
        for (int w = 0; w < DEPTH + 1; w++)
            for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
        n_checks++;
        if (io_Level !== LEVEL_W'(DEPTH) || io_Overflow !== 1'b1 || m_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_fill: got level=%0d ovf=%b, expected %0d/1", io_Level, io_Overflow, DEPTH);
        end
        @(negedge clock);
        io_Out_ready = 1'b1;
        drain();
        n_checks++;
        if (exp_q.size() != 0 || io_Level !== '0 || io_Overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_drain: got pending=%0d level=%0d ovf=%b, expected 0/0/1", exp_q.size(), io_Level, io_Overflow);
        end
        @(negedge clock);
        io_ClearOverflow = 1'b1;
        @(negedge clock);
        io_ClearOverflow = 1'b0;
        m_overflow = 1'b0;
        #1;
        n_checks++;
        if (io_Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_clear: got ovf=%b, expected 0", io_Overflow);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] last;
        io_Out_ready = 1'b0;
        for (int i = 0; i < DEPTH * 8 + 7; i++) send_byte(8'($urandom), 1'b0);
        n_checks++;
        if (io_Level !== LEVEL_W'(DEPTH)) begin
            n_errors++;
            $display("FAIL push_pop_fill: got level=%0d, expected %0d", io_Level, DEPTH);
        end
        last = 8'($urandom);
        @(negedge clock);
        io_InputBuffer   = last;
        io_BufferChanged = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        io_Out_ready = 1'b1;            // pop coincides with the push edge
        @(posedge clock);
        #1;
        model_byte(last);
        n_checks++;
        if (io_Level !== LEVEL_W'(DEPTH) || io_Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL push_pop_full: got level=%0d ovf=%b, expected %0d/0", io_Level, io_Overflow, DEPTH);
        end
        @(negedge clock);
        io_BufferChanged = 1'b0;
        drain();
        n_checks++;
        if (exp_q.size() != 0 || io_Overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL push_pop_drain: got pending=%0d ovf=%b, expected 0/0", exp_q.size(), io_Overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        io_Out_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(8'($urandom), 1'b0);
        @(negedge clock);
        reset = 1'b1;
        m_bytes.delete();
        exp_q.delete();
        m_overflow = 1'b0;
        #1;
        n_checks++;
        if (io_Out_valid !== 1'b0 || io_Out_data !== 64'd0 || io_Out_count !== 4'd0 || io_Level !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_frame: got valid=%b data=%h count=%0d level=%0d, expected all 0",
                     io_Out_valid, io_Out_data, io_Out_count, io_Level);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        io_Out_ready = 1'b1;
        repeat (4) @(negedge clock);
        v0 = valid_cycles;
        cs_end();
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 0 || io_Level !== '0) begin
            n_errors++;
            $display("FAIL reset_no_flush: got words=%0d level=%0d, expected 0/0", valid_cycles - v0, io_Level);
        end
        cs_start();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        cs_end();
        drain();
        n_checks++;
        if (valid_cycles - v0 !== 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_restart_lane0: got words=%0d pending=%0d, expected 1/0", valid_cycles - v0, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int  n;
            bit  tail_cs;
            cs_start();
            n = $urandom_range(0, 13);
            tail_cs = ($urandom_range(0, 1) == 1) && (n > 0);
            for (int i = 0; i < n; i++) begin
                io_Out_ready = ($urandom_range(0, 3) != 0);
                send_byte(8'($urandom), tail_cs && (i == n - 1));
            end
            if (!tail_cs) cs_end();
        end
        @(negedge clock);
        io_Out_ready = 1'b1;
        drain();
        n_checks++;
        if (exp_q.size() != 0 || io_Level !== '0 || io_Overflow !== m_overflow) begin
            n_errors++;
            $display("FAIL random_end: got pending=%0d level=%0d ovf=%b, expected 0/0/%b",
                     exp_q.size(), io_Level, io_Overflow, m_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial_flush();
        test_simultaneous();
        test_latency();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
